// File: rtl/mem_access.sv
// Memory stage behind the exec ALU: byte/word loads and stores over a req/ack data-memory port.
// Optional misaligned word-access exception output enabled by MEM_ALIGN_EXC_EN.
`ifndef ALUOP_LDB
`define ALUOP_LDB 8'h10
`endif
`ifndef ALUOP_LDW
`define ALUOP_LDW 8'h11
`endif
`ifndef ALUOP_STB
`define ALUOP_STB 8'h12
`endif
`ifndef ALUOP_STW
`define ALUOP_STW 8'h13
`endif

module mem_access #(
    parameter int REG_SIZE = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_op,
    input  logic [REG_SIZE-1:0] in_addr,
    input  logic [REG_SIZE-1:0] in_wdata,
    input  logic [REG_ADDR-1:0] in_rd,
    input  logic                in_wb_en,
    output logic                stall_o,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [REG_SIZE-1:0] dmem_addr,
    output logic [REG_SIZE-1:0] dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic [REG_SIZE-1:0] dmem_rdata,
    input  logic                dmem_ack,
`ifdef MEM_ALIGN_EXC_EN
    output logic                exc_align,
`endif
    output logic                out_valid,
    output logic [REG_SIZE-1:0] out_data,
    output logic [REG_ADDR-1:0] out_rd,
    output logic                out_wb_en
);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t state_r, state_next_s;

    logic is_ldb_s, is_ldw_s, is_stb_s, is_stw_s, is_mem_s;
    logic exc_s, ack_s, accept_s, issue_s, direct_s;

    logic                is_load_r, is_byte_r, wb_en_r;
    logic [1:0]          lane_r;
    logic [REG_ADDR-1:0] rd_r;
    logic [REG_SIZE-1:0] mem_data_s;

    logic                pend_v_r, pend_wb_r;
    logic [REG_SIZE-1:0] pend_data_r;
    logic [REG_ADDR-1:0] pend_rd_r;

    function automatic logic [31:0] load_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    // Decode the incoming op and derive handshake/acceptance conditions.
    always_comb begin
        is_ldb_s = (in_op == `ALUOP_LDB);
        is_ldw_s = (in_op == `ALUOP_LDW);
        is_stb_s = (in_op == `ALUOP_STB);
        is_stw_s = (in_op == `ALUOP_STW);
        is_mem_s = is_ldb_s || is_ldw_s || is_stb_s || is_stw_s;
`ifdef MEM_ALIGN_EXC_EN
        exc_s    = (is_ldw_s || is_stw_s) && (in_addr[1:0] != 2'b00);
`else
        exc_s    = 1'b0;
`endif
        ack_s    = (state_r == REQ) && dmem_ack;
        stall_o  = (state_r == REQ) && !dmem_ack;
        accept_s = in_valid && !stall_o;
        issue_s  = accept_s && is_mem_s && !exc_s;
        // Pass-through ops and faulting word accesses both complete without memory.
        direct_s = accept_s && !issue_s;
    end

    // Next-state logic: REQ is held until ack, and re-entered on a same-cycle new memory op.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) state_next_s = REQ;
                else         state_next_s = IDLE;
            end
            REQ: begin
                if (dmem_ack) state_next_s = issue_s ? REQ : IDLE;
                else          state_next_s = REQ;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Registered memory request plus the context needed to format the load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {REG_SIZE{1'b0}};
            dmem_wdata <= {REG_SIZE{1'b0}};
            dmem_be    <= 4'b0000;
            is_load_r  <= 1'b0;
            is_byte_r  <= 1'b0;
            lane_r     <= 2'b00;
            rd_r       <= {REG_ADDR{1'b0}};
            wb_en_r    <= 1'b0;
        end else if (issue_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_stb_s || is_stw_s;
            dmem_addr  <= {in_addr[REG_SIZE-1:2], 2'b00};
            dmem_be    <= (is_ldb_s || is_stb_s) ? (4'b0001 << in_addr[1:0]) : 4'b1111;
            dmem_wdata <= is_stb_s ? {4{in_wdata[7:0]}} :
                          (is_stw_s ? in_wdata : {REG_SIZE{1'b0}});
            is_load_r  <= is_ldb_s || is_ldw_s;
            is_byte_r  <= is_ldb_s;
            lane_r     <= in_addr[1:0];
            rd_r       <= in_rd;
            wb_en_r    <= in_wb_en;
        end else if (ack_s) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {REG_SIZE{1'b0}};
            dmem_wdata <= {REG_SIZE{1'b0}};
            dmem_be    <= 4'b0000;
        end
    end

    // Load result formatting; stores return zero.
    always_comb begin
        mem_data_s = {REG_SIZE{1'b0}};
        if (is_load_r) mem_data_s = is_byte_r ? load_byte(dmem_rdata, lane_r) : dmem_rdata;
        else           mem_data_s = {REG_SIZE{1'b0}};
    end

    // Write-back payload; a direct op landing on an ack cycle waits one slot in pend_* to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= {REG_SIZE{1'b0}};
            out_rd      <= {REG_ADDR{1'b0}};
            out_wb_en   <= 1'b0;
            pend_v_r    <= 1'b0;
            pend_data_r <= {REG_SIZE{1'b0}};
            pend_rd_r   <= {REG_ADDR{1'b0}};
            pend_wb_r   <= 1'b0;
        end else begin
            if (ack_s) begin
                out_valid <= 1'b1;
                out_data  <= mem_data_s;
                out_rd    <= rd_r;
                out_wb_en <= is_load_r && wb_en_r;
            end else if (pend_v_r) begin
                out_valid <= 1'b1;
                out_data  <= pend_data_r;
                out_rd    <= pend_rd_r;
                out_wb_en <= pend_wb_r;
            end else if (direct_s) begin
                out_valid <= 1'b1;
                out_data  <= in_addr;
                out_rd    <= in_rd;
                out_wb_en <= in_wb_en && !exc_s;
            end else begin
                out_valid <= 1'b0;
                out_data  <= {REG_SIZE{1'b0}};
                out_rd    <= {REG_ADDR{1'b0}};
                out_wb_en <= 1'b0;
            end
            if ((ack_s || pend_v_r) && direct_s) begin
                pend_v_r    <= 1'b1;
                pend_data_r <= in_addr;
                pend_rd_r   <= in_rd;
                pend_wb_r   <= in_wb_en && !exc_s;
            end else if (pend_v_r) begin
                pend_v_r    <= 1'b0;
            end
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    logic pend_exc_r;

    // Alignment exception flag, travelling alongside the write-back payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_align  <= 1'b0;
            pend_exc_r <= 1'b0;
        end else begin
            if (ack_s)         exc_align <= 1'b0;
            else if (pend_v_r) exc_align <= pend_exc_r;
            else if (direct_s) exc_align <= exc_s;
            else               exc_align <= 1'b0;
            if ((ack_s || pend_v_r) && direct_s) pend_exc_r <= exc_s;
            else if (pend_v_r)                   pend_exc_r <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, multi-cycle sequences, and a
// randomized run against a transaction-level model with a behavioural data memory.
`ifndef ALUOP_LDB
`define ALUOP_LDB 8'h10
`endif
`ifndef ALUOP_LDW
`define ALUOP_LDW 8'h11
`endif
`ifndef ALUOP_STB
`define ALUOP_STB 8'h12
`endif
`ifndef ALUOP_STW
`define ALUOP_STW 8'h13
`endif

module tb_mem_access;

    localparam logic [7:0] OP_LDB = `ALUOP_LDB;
    localparam logic [7:0] OP_LDW = `ALUOP_LDW;
    localparam logic [7:0] OP_STB = `ALUOP_STB;
    localparam logic [7:0] OP_STW = `ALUOP_STW;
    localparam logic [7:0] OP_ADD = 8'h01;
`ifdef MEM_ALIGN_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_wb_en = 1'b0;
    logic [7:0]  in_op = 8'h00;
    logic [31:0] in_addr = 32'h0, in_wdata = 32'h0, dmem_rdata = 32'h0;
    logic [4:0]  in_rd = 5'd0;
    logic        dmem_ack = 1'b0;
    logic        stall_o, dmem_req, dmem_we, out_valid, out_wb_en;
    logic [31:0] dmem_addr, dmem_wdata, out_data;
    logic [3:0]  dmem_be;
    logic [4:0]  out_rd;
`ifdef MEM_ALIGN_EXC_EN
    logic        exc_align;
`endif

    mem_access dut (
`ifdef MEM_ALIGN_EXC_EN
        .exc_align(exc_align),
`endif
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .in_wb_en(in_wb_en), .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid),
        .out_data(out_data), .out_rd(out_rd), .out_wb_en(out_wb_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input logic wb);
        in_valid = v; in_op = op; in_addr = a; in_wdata = wd; in_rd = rd; in_wb_en = wb;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic        wb;
        int          delay;
        logic [31:0] rdata;
        logic        exp_req, exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_data;
        logic        exp_wb, exp_exc;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(1'b1, v.op, v.addr, v.wdata, v.rd, v.wb);
        @(negedge clk);
        in_valid = 1'b0;
        if (!v.exp_req) begin
            chk({p, "_valid"}, out_valid, 1'b1);
            chk({p, "_data"}, out_data, v.exp_data);
            chk({p, "_wb"}, out_wb_en, v.exp_wb);
            chk({p, "_rd"}, out_rd, v.rd);
            chk({p, "_noreq"}, dmem_req, 1'b0);
`ifdef MEM_ALIGN_EXC_EN
            chk({p, "_exc"}, exc_align, v.exp_exc);
`endif
        end else begin
            chk({p, "_req"}, dmem_req, 1'b1);
            chk({p, "_addr"}, dmem_addr, v.exp_addr);
            chk({p, "_be"}, dmem_be, v.exp_be);
            chk({p, "_we"}, dmem_we, v.exp_we);
            if (v.exp_we) chk({p, "_wdata"}, dmem_wdata, v.exp_wdata);
            for (int i = 0; i < v.delay; i++) begin
                chk({p, "_stall_hi"}, stall_o, 1'b1);
                chk({p, "_early_valid"}, out_valid, 1'b0);
                @(negedge clk);
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            #1 chk({p, "_stall_ack"}, stall_o, 1'b0);
            @(negedge clk);
            dmem_ack = 1'b0;
            chk({p, "_valid"}, out_valid, 1'b1);
            chk({p, "_data"}, out_data, v.exp_data);
            chk({p, "_wb"}, out_wb_en, v.exp_wb);
            if (v.exp_wb) chk({p, "_rd"}, out_rd, v.rd);
            chk({p, "_req_drop"}, dmem_req, 1'b0);
        end
        @(negedge clk);
        chk({p, "_pulse"}, out_valid, 1'b0);
    endtask

    // ---------------- randomized model ----------------
    typedef struct { logic [31:0] data; logic [4:0] rd; logic wb; logic exc; bit chk_rd; } out_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

    out_t        exp_out[$];
    req_t        exp_req[$];
    logic [31:0] mem_model[logic [31:0]];
    logic [31:0] mem_dev[logic [31:0]];
    bit          outstanding = 1'b0, in_prog = 1'b0;
    int          cnt = 0;
    req_t        cur;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_word(a);
    endfunction
    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return mem_dev.exists(a) ? mem_dev[a] : init_word(a);
    endfunction

    // Expected effect of one accepted instruction, from the architectural rules.
    task automatic model_accept(input logic [7:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] rd, input logic wb);
        bit ld, st, byte_op, exc;
        int lane;
        logic [31:0] wa, w, b;
        out_t o;
        req_t r;
        ld = (op == OP_LDB) || (op == OP_LDW);
        st = (op == OP_STB) || (op == OP_STW);
        byte_op = (op == OP_LDB) || (op == OP_STB);
        lane = int'(a % 4);
        exc = EXC_EN && (ld || st) && !byte_op && (lane != 0);
        if (!(ld || st) || exc) begin
            o = '{a, rd, exc ? 1'b0 : wb, exc, 1'b1};
            exp_out.push_back(o);
            return;
        end
        wa = a - (a % 4);
        w = model_rd(wa);
        b = byte_op ? (32'h1 << lane) : 32'hF;
        r.addr = wa; r.we = st; r.be = b[3:0];
        r.wdata = (op == OP_STB) ? (wd % 256) * 32'h01010101 : wd;
        exp_req.push_back(r);
        outstanding = 1'b1;
        if (op == OP_LDW) o = '{w, rd, wb, 1'b0, 1'b1};
        else if (op == OP_LDB) begin
            b = (w >> (8 * lane)) % 256;
            o = '{(b >= 32'h80) ? (b + 32'hFFFFFF00) : b, rd, wb, 1'b0, 1'b1};
        end else begin
            if (op == OP_STW) mem_model[wa] = wd;
            else mem_model[wa] = (w & ~(32'hFF << (8 * lane))) | ((wd % 256) << (8 * lane));
            o = '{32'h0, rd, 1'b0, 1'b0, 1'b0};
        end
        exp_out.push_back(o);
    endtask

    task automatic rand_cycle(input bit drive_en);
        out_t e;
        int   k;
        logic [31:0] w, a;
        logic [7:0]  op;
        @(negedge clk);
        if (out_valid) begin
            if (exp_out.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_spurious_valid: got out_valid=1 data 0x%08h, required none", out_data);
            end else begin
                e = exp_out.pop_front();
                chk("rnd_data", out_data, e.data);
                chk("rnd_wb", out_wb_en, e.wb);
                if (e.chk_rd) chk("rnd_rd", out_rd, e.rd);
`ifdef MEM_ALIGN_EXC_EN
                chk("rnd_exc", exc_align, e.exc);
`endif
            end
        end
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        if (in_prog && !dmem_req) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_req_dropped: got dmem_req=0, required 1 until ack");
            in_prog = 1'b0;
        end
        if (dmem_req && !in_prog) begin
            if (exp_req.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_unexpected_req: got dmem_req=1 addr 0x%08h, required 0", dmem_addr);
            end else begin
                cur = exp_req.pop_front();
                chk("rnd_req_addr", dmem_addr, cur.addr);
                chk("rnd_req_we", dmem_we, cur.we);
                chk("rnd_req_be", dmem_be, cur.be);
                if (cur.we) chk("rnd_req_wdata", dmem_wdata, cur.wdata);
                in_prog = 1'b1;
                cnt = $urandom_range(0, 3);
            end
        end else if (in_prog) begin
            chk("rnd_req_hold", dmem_addr, cur.addr);
        end
        if (in_prog) begin
            if (cnt == 0) begin
                dmem_ack = 1'b1;
                dmem_rdata = dev_rd(dmem_addr);
                if (dmem_we) begin
                    w = dev_rd(dmem_addr);
                    for (int l = 0; l < 4; l++)
                        if (dmem_be[l]) w[8*l +: 8] = dmem_wdata[8*l +: 8];
                    mem_dev[dmem_addr] = w;
                end
                in_prog = 1'b0;
                outstanding = 1'b0;
            end else begin
                cnt--;
            end
        end else if (!dmem_req && $urandom_range(0, 7) == 0) begin
            dmem_ack = 1'b1;
        end
        #1 chk("rnd_stall", stall_o, outstanding);
        if (drive_en) begin
            k = $urandom_range(0, 5);
            case (k)
                0: op = OP_LDB;
                1: op = OP_LDW;
                2: op = OP_STB;
                3: op = OP_STW;
                4: op = OP_ADD;
                default: op = 8'h40 + 8'($urandom_range(0, 15));
            endcase
            a = (k < 4) ? 32'h100 + $urandom_range(0, 63) : $urandom;
            drive($urandom_range(0, 3) != 0, op, a, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
            if (in_valid && !outstanding) model_accept(in_op, in_addr, in_wdata, in_rd, in_wb_en);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_ADD, 32'h1234, 32'h0, 5'd3, 1'b1, 0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1234, 1'b1, 1'b0};
        vecs[1] = '{OP_LDW, 32'h100, 32'h0, 5'd4, 1'b1, 2, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[2] = '{OP_LDB, 32'h103, 32'h0, 5'd5, 1'b1, 0, 32'h80FF0011, 1'b1, 1'b0, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0};
        vecs[3] = '{OP_LDB, 32'h101, 32'h0, 5'd6, 1'b1, 1, 32'h80FF0011, 1'b1, 1'b0, 32'h100, 4'h2, 32'h0, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{OP_STB, 32'h202, 32'hAB, 5'd7, 1'b1, 1, 32'h0, 1'b1, 1'b1, 32'h200, 4'h4, 32'hABABABAB, 32'h0, 1'b0, 1'b0};
        vecs[5] = '{OP_STW, 32'h3FC, 32'h12345678, 5'd8, 1'b1, 0, 32'h0, 1'b1, 1'b1, 32'h3FC, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{OP_LDB, 32'h102, 32'h0, 5'd9, 1'b1, 3, 32'h007F0000, 1'b1, 1'b0, 32'h100, 4'h4, 32'h0, 32'h0000007F, 1'b1, 1'b0};
        vecs[7] = '{8'h55, 32'hFFFFFFFF, 32'h0, 5'd31, 1'b0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0};
`ifdef MEM_ALIGN_EXC_EN
        vecs[8] = '{OP_LDW, 32'h102, 32'h0, 5'd10, 1'b1, 0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h102, 1'b0, 1'b1};
        vecs[9] = '{OP_STW, 32'h207, 32'hA5A50001, 5'd11, 1'b1, 0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h207, 1'b0, 1'b1};
`else
        vecs[8] = '{OP_LDW, 32'h102, 32'h0, 5'd10, 1'b1, 1, 32'h0BADF00D, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h0BADF00D, 1'b1, 1'b0};
        vecs[9] = '{OP_STW, 32'h207, 32'hA5A50001, 5'd11, 1'b1, 0, 32'h0, 1'b1, 1'b1, 32'h204, 4'hF, 32'hA5A50001, 32'h0, 1'b0, 1'b0};
`endif

        // Reset state
        @(negedge clk);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_be", dmem_be, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Back-to-back LDW then STW, each acked in its first REQ cycle
        @(negedge clk);
        drive(1'b1, OP_LDW, 32'h110, 32'h0, 5'd12, 1'b1);
        @(negedge clk);
        chk("b2b_req1", dmem_req, 1'b1);
        chk("b2b_addr1", dmem_addr, 32'h110);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1 chk("b2b_stall1", stall_o, 1'b0);
        drive(1'b1, OP_STW, 32'h120, 32'h55AA55AA, 5'd13, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_req2", dmem_req, 1'b1);
        chk("b2b_addr2", dmem_addr, 32'h120);
        chk("b2b_we2", dmem_we, 1'b1);
        chk("b2b_wdata2", dmem_wdata, 32'h55AA55AA);
        chk("b2b_valid1", out_valid, 1'b1);
        chk("b2b_data1", out_data, 32'hCAFEF00D);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("b2b_req_drop", dmem_req, 1'b0);
        chk("b2b_valid2", out_valid, 1'b1);
        chk("b2b_wb2", out_wb_en, 1'b0);
        chk("b2b_data2", out_data, 32'h0);
        @(negedge clk);
        chk("b2b_pulse", out_valid, 1'b0);

        // Pass-through accepted in the ack cycle, followed by another pass-through
        @(negedge clk);
        drive(1'b1, OP_LDB, 32'h131, 32'h0, 5'd14, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000FE00;
        #1 drive(1'b1, OP_ADD, 32'h77, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("ord_load", out_data, 32'hFFFFFFFE);
        chk("ord_load_rd", out_rd, 5'd14);
        drive(1'b1, OP_ADD, 32'h88, 32'h0, 5'd8, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ord_p1_valid", out_valid, 1'b1);
        chk("ord_p1_data", out_data, 32'h77);
        chk("ord_p1_rd", out_rd, 5'd7);
        @(negedge clk);
        chk("ord_p2_valid", out_valid, 1'b1);
        chk("ord_p2_data", out_data, 32'h88);
        @(negedge clk);
        chk("ord_pulse", out_valid, 1'b0);

        // Ack while idle is ignored
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle_ack_valid", out_valid, 1'b0);
        chk("idle_ack_req", dmem_req, 1'b0);

        // Reset in the middle of an access
        drive(1'b1, OP_LDW, 32'h140, 32'h0, 5'd15, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_req", dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", dmem_req, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_stall", stall_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", stall_o, 1'b0);
        chk("post_rst_req", dmem_req, 1'b0);
        drive(1'b1, OP_ADD, 32'hBEEF, 32'h0, 5'd2, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_pass", out_data, 32'hBEEF);
        chk("post_rst_pass_valid", out_valid, 1'b1);

        // Randomized run against the model
        for (int c = 0; c < 2000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 60; c++) begin
            if (exp_out.size() == 0 && exp_req.size() == 0 && !outstanding && !in_prog) break;
            rand_cycle(1'b0);
        end
        chk("drain_out", exp_out.size(), 32'd0);
        chk("drain_req", exp_req.size(), 32'd0);
        chk("drain_stall", outstanding, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
